// File: rtl/serial_bus_pkg.sv
// Shared types for the two-master split-capable bus arbiter: FSM states,
// master IDs and the default split timeout.
package serial_bus_pkg;

  localparam int SPLIT_TIMEOUT_DEFAULT = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M1 = 2'd1,
    GNT_M2 = 2'd2
  } arb_state_t;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_id_t;

endpackage

// File: rtl/split_timer.sv
// Parked-master watchdog: counts while enabled, restarts on clear, and flags
// the cycle on which the last allowed count has been reached.
module split_timer
  import serial_bus_pkg::*;
#(
  parameter int LIMIT = SPLIT_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX  = CW'(LIMIT);

  logic [CW-1:0] count;

  // Saturates at LIMIT so the count never wraps if enable lingers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Non-preemptive two-master bus arbiter with split-transaction parking,
// resume priority for the released master and a timeout-forced release.
module bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int SPLIT_TIMEOUT = SPLIT_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       split,
  input  logic       split_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       bus_busy,
  output logic       split_pending,
  output logic       split_owner,
  output logic       split_abort,
  output arb_state_t dbg_state
);

  // Bus protocol: a master holds req high for its whole transaction and
  // drops it to release; grant is registered and only changes on clock edges.

  arb_state_t state, next_state;
  master_id_t owner_q, resume_id;
  logic       resume_valid;
  logic       arb_en;
  logic       owning, pend_survives, take_split, done_hit, timeout_hit, expire;
  logic       elig_m1, elig_m2;
  master_id_t cur_owner;

  assign owning        = (state == GNT_M1) || (state == GNT_M2);
  assign cur_owner     = (state == GNT_M2) ? M2 : M1;
  assign pend_survives = split_pending && !split_done;
  assign take_split    = split && owning && !pend_survives;
  assign done_hit      = split_done && split_pending;
  assign timeout_hit   = expire && !split_done;
  assign elig_m1       = m1_req && !(split_pending && owner_q == M1);
  assign elig_m2       = m2_req && !(split_pending && owner_q == M2);

  split_timer #(.LIMIT(SPLIT_TIMEOUT)) u_split_timer (
    .clock  (clock),
    .rst    (rst),
    .clear  (take_split),
    .enable (split_pending),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (arb_en) begin
          if (elig_m2 && (!elig_m1 || (resume_valid && resume_id == M2))) begin
            next_state = GNT_M2;
          end else if (elig_m1) begin
            next_state = GNT_M1;
          end
        end
      end
      GNT_M1:  if (take_split || !m1_req) next_state = IDLE;
      GNT_M2:  if (take_split || !m2_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // arb_en holds off arbitration for the first edge after reset release so
  // the first grant is at least a full cycle away from rst deasserting.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      arb_en        <= 1'b0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      bus_busy      <= 1'b0;
      split_pending <= 1'b0;
      owner_q       <= M1;
      split_abort   <= 1'b0;
      resume_valid  <= 1'b0;
      resume_id     <= M1;
    end else begin
      arb_en      <= 1'b1;
      state       <= next_state;
      m1_grant    <= (next_state == GNT_M1);
      m2_grant    <= (next_state == GNT_M2);
      bus_busy    <= (next_state != IDLE);
      split_abort <= timeout_hit;

      if (take_split) begin
        split_pending <= 1'b1;
        owner_q       <= cur_owner;
      end else if (split_done || timeout_hit) begin
        split_pending <= 1'b0;
      end

      // A master released by split_done gets one shot at top priority.
      if (done_hit) begin
        resume_valid <= 1'b1;
        resume_id    <= owner_q;
      end else if (state == IDLE && next_state != IDLE) begin
        resume_valid <= 1'b0;
      end
    end
  end

  assign split_owner = owner_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter with a short split timeout,
// plus hand-written reset sequences.
module tb_bus_arbiter;
  import serial_bus_pkg::*;

  localparam int TMO = 8;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       m1_req = 1'b0, m2_req = 1'b0, split = 1'b0, split_done = 1'b0;
  logic       m1_grant, m2_grant, bus_busy, split_pending, split_owner, split_abort;
  arb_state_t dbg_state;

  always #5 clock = ~clock;

  bus_arbiter #(.SPLIT_TIMEOUT(TMO)) dut (
    .clock         (clock),
    .rst           (rst),
    .m1_req        (m1_req),
    .m2_req        (m2_req),
    .split         (split),
    .split_done    (split_done),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .bus_busy      (bus_busy),
    .split_pending (split_pending),
    .split_owner   (split_owner),
    .split_abort   (split_abort),
    .dbg_state     (dbg_state)
  );

  // Expected word: {m1_grant, m2_grant, bus_busy, split_pending, split_owner, split_abort}
  typedef struct {
    logic       m1, m2, sp, sd;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [5:0] pk(logic g1, logic g2, logic pend, logic own, logic ab);
    return {g1, g2, g1 | g2, pend, own, ab};
  endfunction

  function automatic void add(logic m1, logic m2, logic sp, logic sd,
                              logic g1, logic g2, logic pend, logic own, logic ab);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.sp = sp; v.sd = sd;
    v.exp = pk(g1, g2, pend, own, ab);
    tbl.push_back(v);
  endfunction

  task automatic apply(input logic m1, input logic m2, input logic sp, input logic sd);
    m1_req = m1; m2_req = m2; split = sp; split_done = sd;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // split_owner is only meaningful while a split is pending.
  task automatic check(input string name);
    logic [5:0] exp, act, mask;
    exp  = exp_q.pop_front();
    act  = {m1_grant, m2_grant, bus_busy, split_pending, split_owner, split_abort};
    mask = exp[2] ? 6'b111111 : 6'b111101;
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got g1,g2,busy,pend,own,abort=%b, want %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input arb_state_t want);
    n_vec++;
    if (dbg_state !== want) begin
      n_err++;
      $display("FAIL %s: got state %0d, want %0d", name, dbg_state, want);
    end
  endtask

  initial begin
    // Arbitration, hand-off and no-preemption
    add(0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0, 1,0,0,0,0);
    for (int i = 0; i < 4; i++) add(1,1,0,0, 1,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(1,1,0,0, 0,1,0,0,0);
    add(1,1,0,0, 0,1,0,0,0);
    add(1,0,0,0, 0,0,0,0,0);
    add(1,0,0,0, 1,0,0,0,0);
    // M1 split, M2 served, second split ignored, resume of M1
    add(1,1,1,0, 0,0,1,0,0);
    add(1,1,0,0, 0,1,1,0,0);
    add(1,1,1,0, 0,1,1,0,0);
    add(1,1,0,1, 0,1,0,0,0);
    add(1,1,0,0, 0,1,0,0,0);
    add(1,0,0,0, 0,0,0,0,0);
    add(1,1,0,0, 1,0,0,0,0);
    // M2 split and resumed ahead of M1
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(1,1,1,0, 0,0,1,1,0);
    add(1,1,0,0, 1,0,1,1,0);
    add(1,1,0,1, 1,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(1,1,0,0, 0,1,0,0,0);
    add(0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0);
    // Stray split / split_done while idle
    add(0,0,1,0, 0,0,0,0,0);
    add(0,0,0,1, 0,0,0,0,0);
    // split and split_done together, then timeout of the new split
    add(1,0,0,0, 1,0,0,0,0);
    add(1,1,1,0, 0,0,1,0,0);
    add(1,1,0,0, 0,1,1,0,0);
    add(1,1,1,1, 0,0,1,1,0);
    add(1,1,0,0, 1,0,1,1,0);
    add(0,1,0,0, 0,0,1,1,0);
    for (int i = 0; i < 5; i++) add(0,1,0,0, 0,0,1,1,0);
    add(0,1,0,0, 0,0,0,0,1);
    add(0,1,0,0, 0,1,0,0,0);
    // split_done on the timeout edge beats the abort
    add(0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0, 1,0,0,0,0);
    add(1,0,1,0, 0,0,1,0,0);
    for (int i = 0; i < 7; i++) add(1,0,0,0, 0,0,1,0,0);
    add(1,0,0,1, 0,0,0,0,0);
    add(1,0,0,0, 1,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0);

    // Power-on reset
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(pk(0,0,0,0,0));
    check("reset_async");
    check_state("reset_state", IDLE);
    apply(1,1,0,0);
    tick();
    tick();
    exp_q.push_back(pk(0,0,0,0,0));
    check("reset_held");
    apply(0,0,0,0);
    #2 rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].m1, tbl[i].m2, tbl[i].sp, tbl[i].sd);
      exp_q.push_back(tbl[i].exp);
      tick();
      check($sformatf("vec%0d", i));
    end

    // Reset during GNT_M2 with M1 parked
    apply(1,0,0,0);
    tick();
    exp_q.push_back(pk(1,0,0,0,0));
    check("rst_seq_m1");
    apply(1,1,1,0);
    tick();
    exp_q.push_back(pk(0,0,1,0,0));
    check("rst_seq_split");
    apply(1,1,0,0);
    tick();
    exp_q.push_back(pk(0,1,1,0,0));
    check("rst_seq_m2");
    check_state("rst_seq_state", GNT_M2);
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(pk(0,0,0,0,0));
    check("rst_async_mid");
    check_state("rst_mid_state", IDLE);
    tick();
    exp_q.push_back(pk(0,0,0,0,0));
    check("rst_mid_held");
    #3 rst = 1'b1;
    tick();
    exp_q.push_back(pk(0,0,0,0,0));
    check("rst_first_edge");
    tick();
    exp_q.push_back(pk(1,0,0,0,0));
    check("rst_m1_grant");
    apply(0,0,0,0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
